// File: rtl/ef_tmr32_pkg.sv
// Shared types for the TMR32 fault-conditioning path.
package ef_tmr32_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_QUAL  = 2'd1,
        ST_FAULT = 2'd2
    } flt_state_e;

endpackage

// File: rtl/ef_tmr32_sync.sv
// N-stage synchronizer for an asynchronous level; clears to 0 on reset.
module ef_tmr32_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ef_tmr32_fault_cond.sv
// Fault pin conditioner: polarity fix, synchronizer, length filter, latch/cbc exit,
// software force, and a saturating count of fault entries.
module ef_tmr32_fault_cond
    import ef_tmr32_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FLT_CW      = 8,
    parameter int EVT_CW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flt_in,
    input  logic              flt_pol,
    input  logic              flt_en,
    input  logic [FLT_CW-1:0] flt_len,
    input  logic              flt_latch,
    input  logic              flt_sw,
    input  logic              flt_clr,
    input  logic              evt_clr,
    output logic              pwm_fault,
    output logic              flt_act,
    output logic [ST_W-1:0]   flt_state,
    output logic [EVT_CW-1:0] evt_cnt
);

    logic              act_raw;
    flt_state_e        state_q, state_d;
    logic [FLT_CW-1:0] qcnt_q, qcnt_d;
    logic [EVT_CW-1:0] evt_q, evt_d;
    logic              pwm_q;

    // Polarity is folded in before synchronizing so flt_act is always active-high.
    assign act_raw = ~(flt_in ^ flt_pol);

    ef_tmr32_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(act_raw),
        .q_o(flt_act)
    );

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        if (flt_sw) begin
            state_d = ST_FAULT;
            qcnt_d  = '0;
        end else if (!flt_en) begin
            state_d = ST_IDLE;
            qcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flt_act) begin
                        if (flt_len == '0) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_QUAL;
                            qcnt_d  = FLT_CW'(1);
                        end
                    end
                end
                ST_QUAL: begin
                    if (!flt_act) begin
                        state_d = ST_IDLE;
                        qcnt_d  = '0;
                    end else if (qcnt_q >= flt_len) begin
                        state_d = ST_FAULT;
                        qcnt_d  = '0;
                    end else if (qcnt_q != '1) begin
                        qcnt_d = qcnt_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Latched mode only releases on an explicit clear once the pin is quiet.
                    if (!flt_act && (!flt_latch || flt_clr)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    qcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        evt_d = evt_q;
        if (evt_clr) begin
            evt_d = '0;
        end else if (state_d == ST_FAULT && state_q != ST_FAULT && evt_q != '1) begin
            evt_d = evt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            qcnt_q  <= '0;
            evt_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            evt_q   <= evt_d;
            pwm_q   <= (state_d == ST_FAULT);
        end
    end

    assign pwm_fault = pwm_q;
    assign flt_state = state_q;
    assign evt_cnt   = evt_q;

endmodule
